// File: rtl/hex_word_reader.sv
// Holds a datapath word and shows a four-nibble window of it on the HEX digits.
// The window moves with the pushbuttons or by auto-scroll, with optional leading-zero blanking.

module hex_key_edge (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    logic [1:0] sync;
    logic       sync_d;

    // Two-flop synchronizer, then a registered falling-edge pulse
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            sync   <= 2'b11;
            sync_d <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync   <= {sync[0], key_n};
            sync_d <= sync[1];
            press  <= sync_d & ~sync[1];
        end
    end
endmodule

module hex_word_reader #(
    parameter int WORD_W     = 32,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              key_next_n,
    input  logic              key_prev_n,
    input  logic              auto_en,
    input  logic              blank_lz,
    output logic [15:0]       hex_value,
    output logic [3:0]        hex_off,
    output logic [3:0]        offset,
    output logic              at_top,
    output logic              at_bottom
);
    localparam int N       = WORD_W / 4;
    localparam int MAX_OFF = N - 4;
    localparam int CNT_W   = $clog2(SCROLL_DIV);

    localparam logic [3:0]       OFF_MAX = 4'(MAX_OFF);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(SCROLL_DIV - 1);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    logic [1:0]        state;
    logic [WORD_W-1:0] held;
    logic [CNT_W-1:0]  scroll_cnt;
    logic [1:0]        keys_n;
    logic [1:0]        press;
    logic              accept;
    logic [15:0]       window;
    logic [3:0]        lz_off;
    logic [3:0]        off_nxt;

    assign keys_n = {key_prev_n, key_next_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        hex_key_edge u_key (
            .CLOCK_50 (CLOCK_50),
            .rst      (rst),
            .key_n    (keys_n[k]),
            .press    (press[k])
        );
    end

    assign word_ready = (state != S_LOAD);
    assign accept     = word_valid && word_ready;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state      <= S_EMPTY;
            held       <= '0;
            offset     <= 4'd0;
            scroll_cnt <= '0;
        end else if (accept) begin
            state      <= S_LOAD;
            held       <= word_in;
            offset     <= 4'd0;
            scroll_cnt <= '0;
        end else begin
            case (state)
                S_LOAD:  state <= S_SHOW;
                S_SHOW: begin
                    // Key presses restart the auto-scroll interval
                    if (press[0] && press[1]) begin
                        scroll_cnt <= '0;
                    end else if (press[0]) begin
                        if (offset != OFF_MAX) offset <= offset + 4'd1;
                        scroll_cnt <= '0;
                    end else if (press[1]) begin
                        if (offset != 4'd0) offset <= offset - 4'd1;
                        scroll_cnt <= '0;
                    end else if (auto_en && scroll_cnt == CNT_TC) begin
                        offset     <= (offset == OFF_MAX) ? 4'd0 : offset + 4'd1;
                        scroll_cnt <= '0;
                    end else if (auto_en) begin
                        scroll_cnt <= scroll_cnt + CNT_W'(1);
                    end else begin
                        scroll_cnt <= '0;
                    end
                end
                S_EMPTY: state <= S_EMPTY;
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign window = 16'(held >> {offset, 2'b00});

    // Digit i blanks when no nonzero nibble sits at or above its position
    always_comb begin
        logic nz;
        nz     = 1'b0;
        lz_off = 4'b0000;
        for (int i = 1; i < 4; i++) begin
            nz = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j >= int'(offset) + i && held[4*j +: 4] != 4'd0) nz = 1'b1;
            end
            lz_off[i] = ~nz;
        end
    end

    assign off_nxt = (state == S_EMPTY) ? 4'b1111 : (blank_lz ? lz_off : 4'b0000);

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            hex_value <= 16'h0000;
            hex_off   <= 4'b1111;
            at_top    <= 1'b0;
            at_bottom <= 1'b1;
        end else begin
            hex_value <= window;
            hex_off   <= off_nxt;
            at_top    <= (offset == OFF_MAX);
            at_bottom <= (offset == 4'd0);
        end
    end
endmodule

// File: tb/tb_hex_word_reader.sv
// Directed bench: stimulus pushes timed expectations, a negedge monitor pops and compares.

module tb_hex_word_reader;
    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] word_in = 32'h0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        key_next_n = 1'b1;
    logic        key_prev_n = 1'b1;
    logic        auto_en = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] hex_value;
    logic [3:0]  hex_off;
    logic [3:0]  offset;
    logic        at_top;
    logic        at_bottom;

    hex_word_reader #(.WORD_W(32), .SCROLL_DIV(4)) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .key_next_n (key_next_n),
        .key_prev_n (key_prev_n),
        .auto_en    (auto_en),
        .blank_lz   (blank_lz),
        .hex_value  (hex_value),
        .hex_off    (hex_off),
        .offset     (offset),
        .at_top     (at_top),
        .at_bottom  (at_bottom)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    localparam logic [5:0] M_HV = 6'd1, M_HO = 6'd2, M_OFF = 6'd4,
                           M_RDY = 6'd8, M_TOP = 6'd16, M_BOT = 6'd32;

    typedef struct {
        int          at;
        string       nm;
        logic [5:0]  m;
        logic [15:0] hv;
        logic [3:0]  ho;
        logic [3:0]  off;
        logic        rdy;
        logic        top;
        logic        bot;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int at, input string nm, input logic [5:0] m,
                             input logic [15:0] hv, input logic [3:0] ho, input logic [3:0] off,
                             input logic rdy, input logic top, input logic bot);
        exp_t e;
        e.at = at; e.nm = nm; e.m = m; e.hv = hv; e.ho = ho; e.off = off;
        e.rdy = rdy; e.top = top; e.bot = bot;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h (cycle %0d)", nm, fld, act, want, cyc);
        end
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            if (e.at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed: due cycle %0d, now %0d", e.nm, e.at, cyc);
            end else begin
                if (e.m[0]) cmp(e.nm, "hex_value", hex_value, e.hv);
                if (e.m[1]) cmp(e.nm, "hex_off", {12'h0, hex_off}, {12'h0, e.ho});
                if (e.m[2]) cmp(e.nm, "offset", {12'h0, offset}, {12'h0, e.off});
                if (e.m[3]) cmp(e.nm, "word_ready", {15'h0, word_ready}, {15'h0, e.rdy});
                if (e.m[4]) cmp(e.nm, "at_top", {15'h0, at_top}, {15'h0, e.top});
                if (e.m[5]) cmp(e.nm, "at_bottom", {15'h0, at_bottom}, {15'h0, e.bot});
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic load(input logic [31:0] w);
        word_in = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic press(input bit nxt, input bit prv, input int hold);
        key_next_n = ~nxt;
        key_prev_n = ~prv;
        repeat (hold) tick();
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int k, m, a, b;
        // Reset state
        tick(); tick();
        expect_at(cyc, "reset", M_HV | M_HO | M_OFF | M_RDY | M_TOP | M_BOT,
                  16'h0000, 4'b1111, 4'd0, 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();

        // Handshake: ready drops for exactly the LOAD cycle
        word_in = 32'h1234ABCD;
        word_valid = 1'b1;
        k = cyc;
        expect_at(k,     "hs_pre",  M_RDY, 16'h0, 4'h0, 4'd0, 1'b1, 1'b0, 1'b0);
        expect_at(k + 1, "hs_load", M_RDY, 16'h0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_at(k + 2, "hs_show", M_HV | M_HO | M_OFF | M_RDY | M_TOP | M_BOT,
                  16'hABCD, 4'b0000, 4'd0, 1'b1, 1'b0, 1'b1);
        tick();
        word_valid = 1'b0;
        repeat (3) tick();

        // Held key: one step, offset three edges after the sampling edge
        key_next_n = 1'b0;
        m = cyc;
        expect_at(m + 3,  "key_early", M_OFF, 16'h0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_at(m + 4,  "key_step",  M_OFF, 16'h0, 4'h0, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_at(m + 5,  "key_win",   M_HV | M_BOT, 16'h4ABC, 4'h0, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_at(m + 12, "key_hold",  M_OFF, 16'h0, 4'h0, 4'd1, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        key_next_n = 1'b1;
        repeat (4) tick();

        // Saturation at the top, then one step back
        repeat (6) press(1'b1, 1'b0, 2);
        expect_at(cyc, "sat_top", M_HV | M_OFF | M_TOP, 16'h1234, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0);
        tick();
        press(1'b0, 1'b1, 2);
        expect_at(cyc, "prev", M_HV | M_OFF | M_TOP, 16'h234A, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();

        // Leading-zero blanking
        blank_lz = 1'b1;
        load(32'h000000F0);
        expect_at(cyc, "lz_f0", M_HV | M_HO | M_OFF, 16'h00F0, 4'b1100, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        blank_lz = 1'b0;
        tick(); tick();
        expect_at(cyc, "lz_off", M_HO, 16'h0, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        blank_lz = 1'b1;
        load(32'h00000000);
        expect_at(cyc, "lz_zero", M_HV | M_HO, 16'h0000, 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        load(32'h00050000);
        press(1'b1, 1'b0, 2);
        press(1'b1, 1'b0, 2);
        expect_at(cyc, "lz_off2", M_HV | M_HO | M_OFF, 16'h0500, 4'b1000, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();

        // Auto-scroll with wrap, key restarts the interval, both keys cancel
        blank_lz = 1'b0;
        load(32'h1234ABCD);
        auto_en = 1'b1;
        a = cyc;
        expect_at(a + 3,  "auto_0",   M_OFF, 16'h0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_at(a + 4,  "auto_1",   M_OFF, 16'h0, 4'h0, 4'd1, 1'b0, 1'b0, 1'b0);
        expect_at(a + 8,  "auto_2",   M_OFF, 16'h0, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_at(a + 12, "auto_3",   M_OFF, 16'h0, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_at(a + 16, "auto_4",   M_OFF, 16'h0, 4'h0, 4'd4, 1'b0, 1'b0, 1'b0);
        expect_at(a + 19, "auto_hold", M_OFF | M_TOP, 16'h0, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0);
        expect_at(a + 20, "auto_wrap", M_OFF, 16'h0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        expect_at(a + 21, "auto_win", M_HV | M_BOT, 16'hABCD, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_at(a + 25, "auto_key", M_OFF, 16'h0, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_at(a + 28, "auto_rst", M_OFF, 16'h0, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0);
        expect_at(a + 29, "auto_nxt", M_OFF, 16'h0, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0);
        repeat (21) tick();
        key_next_n = 1'b0;
        tick(); tick();
        key_next_n = 1'b1;
        repeat (7) tick();
        auto_en = 1'b0;
        tick(); tick();
        b = cyc;
        key_next_n = 1'b0;
        key_prev_n = 1'b0;
        expect_at(b + 4, "both_a", M_OFF, 16'h0, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0);
        expect_at(b + 8, "both_b", M_OFF, 16'h0, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        key_next_n = 1'b1;
        key_prev_n = 1'b1;
        repeat (8) tick();

        // Asynchronous reset during LOAD, keys ignored while empty
        word_in = 32'hCAFE0000;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        #1 rst = 1'b0;
        expect_at(cyc, "arst", M_HV | M_HO | M_OFF | M_RDY | M_TOP | M_BOT,
                  16'h0000, 4'b1111, 4'd0, 1'b1, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        press(1'b1, 1'b0, 2);
        tick(); tick();
        expect_at(cyc, "empty_key", M_HO | M_OFF | M_RDY, 16'h0, 4'b1111, 4'd0, 1'b1, 1'b0, 1'b0);
        tick();
        load(32'h1234ABCD);
        expect_at(cyc, "reload", M_HV | M_HO | M_OFF, 16'hABCD, 4'b0000, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never checked (due cycle %0d)", e.nm, e.at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_word_reader.md
Name: hex_word_reader

Overview:
Read-out counterpart to the keypad operand-entry front end. It accepts a full-width word from the datapath (ALU result, register-file read data) over a valid/ready handshake and presents it nibble by nibble on the four-digit HEX display. The displayed window is moved with the pushbuttons, or scrolls automatically, and optional leading-zero blanking is applied. Its outputs drive the existing HexEncoder instances: hex_value feeds the .in ports and hex_off feeds the .off ports.

Parameters:
WORD_W, 32, captured word width; multiple of 4, range 16..64.
SCROLL_DIV, 25000000, CLOCK_50 cycles between auto-scroll steps; must be >= 2.

Ports:
CLOCK_50  in  1  system clock; all state changes on its posedge.
rst  in  1  asynchronous, active-low reset.
word_in  in  WORD_W  word to display.
word_valid  in  1  word_in is valid this cycle.
word_ready  out  1  block can accept a word.
key_next_n  in  1  raw pushbutton, active-low (pressed = 0); moves the window toward MS nibbles.
key_prev_n  in  1  raw pushbutton, active-low; moves the window toward LS nibbles.
auto_en  in  1  enable auto-scroll.
blank_lz  in  1  enable leading-zero blanking.
hex_value  out  16  four nibbles; [15:12] is the leftmost digit (HEX3), [3:0] is HEX0.
hex_off  out  4  per-digit blank; bit i blanks digit i.
offset  out  4  current window offset, in nibbles.
at_top  out  1  offset == MAX_OFF.
at_bottom  out  1  offset == 0.

Behaviour:
- Definitions: N = WORD_W/4; MAX_OFF = N-4. Window digit i (i = 0..3) shows nibble[offset+i] of the held word.
- Reset (rst=0, asynchronous):
  - Registers: state=EMPTY, held word=0, offset=0, scroll counter=0, key synchronizer and edge flops=1.
  - Outputs: word_ready=1, hex_value=0, hex_off=4'b1111, offset=0, at_bottom=1, at_top=0.
- State machine:
  - EMPTY: nothing held. word_ready=1. Keys and auto-scroll are ignored. hex_off=1111.
  - LOAD: entered on the edge where word_valid && word_ready. At that edge the held word <= word_in, offset <= 0 and the scroll counter <= 0. word_ready=0 for exactly this one cycle. Always goes to SHOW on the next edge.
  - SHOW: word_ready=1. Keys and auto-scroll are active. A new handshake goes to LOAD and discards the current offset.
  - word_valid is ignored while word_ready=0. Nothing needs to be held off; the source simply retries.
- Keys:
  - Each raw key passes through a 2-flop synchronizer, then falling-edge detection, giving a 1-cycle press pulse.
  - Raw falling edge sampled at edge E -> pulse during the cycle after E+2 -> offset updates at E+3.
  - Holding a key produces exactly one pulse. A release produces none.
- Offset update priority in SHOW, highest first:
  1. next and prev pulse in the same cycle: no change, and the scroll counter is cleared.
  2. next: offset+1, saturating at MAX_OFF. Scroll counter cleared.
  3. prev: offset-1, saturating at 0. Scroll counter cleared.
  4. Auto terminal count (auto_en=1 and counter == SCROLL_DIV-1): offset+1, wrapping MAX_OFF -> 0. Counter -> 0.
  5. Otherwise, if auto_en=1, the counter increments.
- auto_en=0 holds the counter at 0.
- A press pulse arriving in LOAD or EMPTY is dropped.
- Output register:
  - hex_value, hex_off, at_top and at_bottom are registered from the held word and offset, with 1-cycle latency.
  - After a LOAD edge, the new word appears on hex_value at the following edge (the SHOW entry edge).
  - The offset port is the offset register itself (no extra latency).
- Leading-zero blanking:
  - With blank_lz=1 in SHOW, digit i (for i = 1..3) is blanked when every word nibble at index >= offset+i is zero.
  - Digit 0 is never blanked in SHOW.
  - With blank_lz=0, hex_off=0000 in SHOW.
  - hex_value still carries the true nibbles when a digit is blanked.
- Reset asserted mid-scroll or mid-LOAD returns to EMPTY immediately, without waiting for a clock edge.

Test Plan:
1. Reset, then word_in=0x1234ABCD with word_valid for 1 cycle -> word_ready=0 for exactly 1 cycle. Next edge: hex_value=0xABCD, hex_off=0000, offset=0, at_bottom=1.
2. Pulse key_next_n low for 10 cycles -> 3 cycles after the sampled edge, offset=1. One cycle later hex_value=0x4ABC. Exactly one step despite the held key.
3. Six further next presses -> offset saturates at 4, hex_value=0x1234, at_top=1. A prev press then gives offset=3, hex_value=0x234A.
4. blank_lz=1, word 0x000000F0, offset 0 -> hex_value=0x00F0, hex_off=4'b1100. blank_lz=0 -> hex_off=0000. Word 0 -> hex_off=1110.
5. With SCROLL_DIV=4 and auto_en=1 -> offset steps 0,1,2,3,4,0 every 4 cycles. A next press mid-count restarts the 4-cycle interval. Both keys pressed in the same cycle -> no offset change.
6. rst low in the cycle after a handshake (LOAD) -> hex_off=1111, word_ready=1, offset=0 asynchronously. Keys are ignored until the next word is loaded.
